// File: rtl/fadd_arbiter.sv
// Round-robin front end that lets N_REQ requesters share a single Float32Add unit.
// One operation is in flight at a time; a watchdog aborts it if the adder never goes idle.
module fadd_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [32*N_REQ-1:0]  req_left,
   input  logic [32*N_REQ-1:0]  req_right,
   input  logic [N_REQ-1:0]     req_addsub,
   output logic [N_REQ-1:0]     resp_valid,
   output logic [31:0]          resp_sum,
   output logic [2:0]           resp_status,
   output logic                 err_timeout,
   output logic                 ctl_busy,
   output logic [31:0]          fa_left,
   output logic [31:0]          fa_right,
   output logic                 fa_addsub,
   output logic                 fa_load,
   input  logic [2:0]           fa_status,
   input  logic                 fa_busy,
   input  logic [31:0]          fa_sum
);

   localparam int unsigned      IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned      WW       = $clog2(TIMEOUT + 1);
   localparam logic [31:0]      NAN_SUM  = 32'h7FC0_0000;
   localparam logic [2:0]       NAN_STAT = 3'b100;
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_RESP
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_rr;
   logic [IW-1:0]     r_winner;
   logic [WW-1:0]     r_wd;
   logic              r_wb;

   logic [IW-1:0]     w_idx;
   logic [IW-1:0]     w_pick;
   logic              w_grant;
   logic              w_wd_expire;
   logic [31:0]       w_left;
   logic [31:0]       w_right;
   logic              w_addsub;
   logic [N_REQ-1:0]  w_win_oh;

   // First valid requester searching upward from r_rr+1; later k overwritten by earlier k
   always_comb begin
      w_idx  = '0;
      w_pick = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_idx = IW'((32'(r_rr) + 32'(k)) % N_REQ);
         if (req_valid[w_idx]) w_pick = w_idx;
      end
   end

   always_comb begin
      w_left   = '0;
      w_right  = '0;
      w_addsub = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick == IW'(i)) begin
            w_left   = req_left[i*32 +: 32];
            w_right  = req_right[i*32 +: 32];
            w_addsub = req_addsub[i];
         end
      end
   end

   assign w_grant     = nRST && (r_state == S_IDLE) && (|req_valid) && !fa_busy;
   assign req_ready   = w_grant ? (ONE_HOT0 << w_pick) : '0;
   assign w_win_oh    = ONE_HOT0 << r_winner;
   // Abort one cycle early so the forced response lands TIMEOUT cycles after fa_load
   assign w_wd_expire = (r_wd == WW'(TIMEOUT - 2));

   always_ff @(posedge clk) begin
      if (!nRST) begin
         r_state     <= S_IDLE;
         r_rr        <= IW'(N_REQ - 1);
         r_winner    <= '0;
         r_wd        <= '0;
         r_wb        <= 1'b0;
         resp_valid  <= '0;
         resp_sum    <= '0;
         resp_status <= '0;
         err_timeout <= 1'b0;
         ctl_busy    <= 1'b0;
         fa_left     <= '0;
         fa_right    <= '0;
         fa_addsub   <= 1'b0;
         fa_load     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  fa_left   <= w_left;
                  fa_right  <= w_right;
                  fa_addsub <= w_addsub;
                  fa_load   <= 1'b1;
                  r_winner  <= w_pick;
                  r_rr      <= w_pick;
                  r_wd      <= '0;
                  ctl_busy  <= 1'b1;
                  r_state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               fa_load <= 1'b0;
               r_wb    <= 1'b0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               r_wd <= r_wd + WW'(1);
               if (w_wd_expire) begin
                  resp_sum    <= NAN_SUM;
                  resp_status <= NAN_STAT;
                  err_timeout <= 1'b1;
                  resp_valid  <= w_win_oh;
                  r_state     <= S_RESP;
               end else if (fa_busy || r_wb) begin
                  r_state <= S_WAIT_DONE;
               end else begin
                  r_wb <= 1'b1;
               end
            end
            S_WAIT_DONE: begin
               r_wd <= r_wd + WW'(1);
               if (!fa_busy) begin
                  resp_sum    <= fa_sum;
                  resp_status <= fa_status;
                  resp_valid  <= w_win_oh;
                  r_state     <= S_RESP;
               end else if (w_wd_expire) begin
                  resp_sum    <= NAN_SUM;
                  resp_status <= NAN_STAT;
                  err_timeout <= 1'b1;
                  resp_valid  <= w_win_oh;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               resp_valid  <= '0;
               err_timeout <= 1'b0;
               ctl_busy    <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter with a behavioural Float32Add stand-in (table lookup, programmable busy length).
module tb_fadd_arbiter;

   localparam int N   = 4;
   localparam int TMO = 64;

   logic            clk = 1'b0;
   logic            nRST = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [32*N-1:0] req_left = '0;
   logic [32*N-1:0] req_right = '0;
   logic [N-1:0]    req_addsub = '0;
   logic [N-1:0]    resp_valid;
   logic [31:0]     resp_sum;
   logic [2:0]      resp_status;
   logic            err_timeout;
   logic            ctl_busy;
   logic [31:0]     fa_left;
   logic [31:0]     fa_right;
   logic            fa_addsub;
   logic            fa_load;
   logic [2:0]      fa_status;
   logic            fa_busy;
   logic [31:0]     fa_sum;

   fadd_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .clk(clk), .nRST(nRST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_left(req_left), .req_right(req_right), .req_addsub(req_addsub),
      .resp_valid(resp_valid), .resp_sum(resp_sum), .resp_status(resp_status),
      .err_timeout(err_timeout), .ctl_busy(ctl_busy),
      .fa_left(fa_left), .fa_right(fa_right), .fa_addsub(fa_addsub), .fa_load(fa_load),
      .fa_status(fa_status), .fa_busy(fa_busy), .fa_sum(fa_sum)
   );

   always #5 clk = ~clk;

   // Adder stand-in: results from a table of hand-computed IEEE-754 sums
   logic        m_busy;
   logic [31:0] m_sum;
   logic [2:0]  m_st;
   int          m_cnt;
   int          m_len;
   logic        m_stuck;

   function automatic logic [34:0] fp_model(input logic [31:0] l, input logic [31:0] r);
      case ({l, r})
         {32'h40490fdb, 32'h402df854}: return {3'b000, 32'h40bb8417};
         {32'h4d001f73, 32'h44030a3d}: return {3'b000, 32'h4D001F94};
         {32'h80000000, 32'h00000000}: return {3'b000, 32'h00000000};
         {32'h7FC00000, 32'h402df854}: return {3'b100, 32'h7FC00000};
         default:                      return {3'b000, 32'hDEADBEEF};
      endcase
   endfunction

   always @(posedge clk) begin
      if (!nRST) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
         m_sum  <= '0;
         m_st   <= '0;
      end else if (fa_load) begin
         {m_st, m_sum} <= fp_model(fa_left, fa_right);
         m_cnt         <= m_len;
         m_busy        <= (m_len > 0);
      end else if (m_busy && !m_stuck) begin
         if (m_cnt > 1) m_cnt <= m_cnt - 1;
         else           m_busy <= 1'b0;
      end
   end

   assign fa_busy   = m_busy;
   assign fa_sum    = m_sum;
   assign fa_status = m_st;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int          rem  [N];
   logic [31:0] op_l [N];
   logic [31:0] op_r [N];
   logic        op_as[N];

   int          g_idx[$];
   int          g_cyc[$];
   int          ld_cyc[$];
   logic [31:0] ld_l[$];
   logic [31:0] ld_r[$];
   logic        ld_as[$];
   int          rs_idx[$];
   int          rs_cyc[$];
   logic [31:0] rs_sum[$];
   logic [2:0]  rs_st[$];
   logic        rs_err[$];
   logic        rs_busy[$];
   int          err_pulses;
   int          bad_grants;

   function automatic int oh_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : -2;
      return r;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = (rem[i] > 0);
         req_left[32*i +: 32]  = op_l[i];
         req_right[32*i +: 32] = op_r[i];
         req_addsub[i]         = op_as[i];
      end
   endtask

   task automatic clear_logs();
      g_idx.delete();  g_cyc.delete();
      ld_cyc.delete(); ld_l.delete(); ld_r.delete(); ld_as.delete();
      rs_idx.delete(); rs_cyc.delete(); rs_sum.delete(); rs_st.delete();
      rs_err.delete(); rs_busy.delete();
      err_pulses = 0;
      bad_grants = 0;
   endtask

   // Sample at negedge, then update requester inputs just after the active edge
   task automatic tick();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_ready & req_valid;
      if (req_ready != '0) begin
         g_idx.push_back(oh_idx(req_ready));
         g_cyc.push_back(cyc);
         if (fa_busy || ((req_ready & ~req_valid) != '0)) bad_grants++;
      end
      if (fa_load) begin
         ld_cyc.push_back(cyc); ld_l.push_back(fa_left);
         ld_r.push_back(fa_right); ld_as.push_back(fa_addsub);
      end
      if (resp_valid != '0) begin
         rs_idx.push_back(oh_idx(resp_valid)); rs_cyc.push_back(cyc);
         rs_sum.push_back(resp_sum); rs_st.push_back(resp_status);
         rs_err.push_back(err_timeout); rs_busy.push_back(ctl_busy);
      end
      if (err_timeout) err_pulses++;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) if (acc[i] && rem[i] > 0) rem[i]--;
      drive_reqs();
   endtask

   task automatic run_until_resp(input int nresp, input int budget, input string name);
      int b;
      b = 0;
      while (rs_idx.size() < nresp && b < budget) begin
         tick();
         b++;
      end
      tests++;
      if (rs_idx.size() < nresp) begin
         fails++;
         $display("FAIL %s_wait: got %0d responses, need %0d within %0d cycles", name, rs_idx.size(), nresp, budget);
      end
   endtask

   task automatic do_reset(input int n);
      nRST = 1'b0;
      m_stuck = 1'b0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; op_l[i] = '0; op_r[i] = '0; op_as[i] = 1'b0;
      end
      drive_reqs();
      repeat (n) tick();
      nRST = 1'b1;
      clear_logs();
   endtask

   task automatic test_reset();
      do_reset(1);
      nRST = 1'b0;
      rem[0] = 1; op_l[0] = 32'h40490fdb; op_r[0] = 32'h402df854; op_as[0] = 1'b1;
      drive_reqs();
      tick(); tick();
      tests++;
      if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b, need 0", req_ready); end
      tests++;
      if (ctl_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, need 0", ctl_busy); end
      tests++;
      if (resp_valid !== '0 || err_timeout !== 1'b0) begin
         fails++; $display("FAIL reset_resp: valid=%b err=%b, need 0", resp_valid, err_timeout);
      end
      tests++;
      if ({fa_left, fa_right, fa_addsub, fa_load} !== '0) begin
         fails++; $display("FAIL reset_fa: left=%h right=%h as=%b load=%b, need 0", fa_left, fa_right, fa_addsub, fa_load);
      end
      tests++;
      if ({resp_sum, resp_status} !== '0) begin
         fails++; $display("FAIL reset_sum: sum=%h st=%b, need 0", resp_sum, resp_status);
      end
      tests++;
      if (rem[0] !== 1) begin fails++; $display("FAIL reset_no_accept: rem0=%0d, need 1", rem[0]); end
      nRST = 1'b1;
      rem[0] = 0;
      drive_reqs();
      clear_logs();
   endtask

   task automatic test_single();
      do_reset(2);
      m_len = 3;
      op_l[0] = 32'h40490fdb; op_r[0] = 32'h402df854; op_as[0] = 1'b1; rem[0] = 1;
      drive_reqs();
      run_until_resp(1, 40, "single");
      tests++;
      if (g_idx.size() != 1 || g_idx[0] != 0) begin
         fails++; $display("FAIL single_grant: n=%0d idx=%0d, need one grant to 0", g_idx.size(), g_idx[0]);
      end
      tests++;
      if (ld_cyc.size() != 1 || ld_cyc[0] != g_cyc[0] + 1) begin
         fails++; $display("FAIL single_load: n=%0d at %0d, need one strobe at %0d", ld_cyc.size(), ld_cyc[0], g_cyc[0] + 1);
      end
      tests++;
      if (ld_l[0] !== 32'h40490fdb || ld_r[0] !== 32'h402df854 || ld_as[0] !== 1'b1) begin
         fails++; $display("FAIL single_operands: %h %h %b, need 40490fdb 402df854 1", ld_l[0], ld_r[0], ld_as[0]);
      end
      tests++;
      if (rs_idx[0] != 0 || rs_sum[0] !== 32'h40bb8417 || rs_st[0] !== 3'b000 || rs_err[0] !== 1'b0) begin
         fails++; $display("FAIL single_resp: idx=%0d sum=%h st=%b err=%b, need 0 40bb8417 000 0", rs_idx[0], rs_sum[0], rs_st[0], rs_err[0]);
      end
      tests++;
      if (rs_cyc[0] != ld_cyc[0] + 5 || rs_busy[0] !== 1'b1) begin
         fails++; $display("FAIL single_latency: resp at +%0d busy=%b, need +5 busy=1", rs_cyc[0] - ld_cyc[0], rs_busy[0]);
      end
      repeat (3) tick();
      tests++;
      if (resp_sum !== 32'h40bb8417 || resp_valid !== '0 || ctl_busy !== 1'b0 || rs_idx.size() != 1) begin
         fails++; $display("FAIL single_hold: sum=%h valid=%b busy=%b n=%0d, need 40bb8417 0 0 1", resp_sum, resp_valid, ctl_busy, rs_idx.size());
      end
   endtask

   task automatic test_no_busy();
      clear_logs();
      m_len = 0;
      rem[0] = 1;
      drive_reqs();
      run_until_resp(1, 40, "no_busy");
      tests++;
      if (rs_cyc[0] - ld_cyc[0] != 4 || rs_sum[0] !== 32'h40bb8417 || rs_idx[0] != 0) begin
         fails++; $display("FAIL no_busy_fallback: resp at +%0d sum=%h idx=%0d, need +4 40bb8417 0", rs_cyc[0] - ld_cyc[0], rs_sum[0], rs_idx[0]);
      end
   endtask

   task automatic test_all_four();
      logic [31:0] exp_sum[N];
      logic [2:0]  exp_st[N];
      exp_sum = '{32'h4D001F94, 32'h00000000, 32'h40bb8417, 32'h7FC00000};
      exp_st  = '{3'b000, 3'b000, 3'b000, 3'b100};
      do_reset(2);
      m_len = 2;
      op_l[0] = 32'h4d001f73; op_r[0] = 32'h44030a3d;
      op_l[1] = 32'h80000000; op_r[1] = 32'h00000000;
      op_l[2] = 32'h40490fdb; op_r[2] = 32'h402df854;
      op_l[3] = 32'h7FC00000; op_r[3] = 32'h402df854;
      for (int i = 0; i < N; i++) begin op_as[i] = 1'b1; rem[i] = 1; end
      drive_reqs();
      run_until_resp(4, 200, "all_four");
      for (int i = 0; i < N; i++) begin
         tests++;
         if (rs_idx[i] != i || rs_sum[i] !== exp_sum[i] || rs_st[i] !== exp_st[i]) begin
            fails++; $display("FAIL all_four_resp%0d: idx=%0d sum=%h st=%b, need %0d %h %b", i, rs_idx[i], rs_sum[i], rs_st[i], i, exp_sum[i], exp_st[i]);
         end
      end
      tests++;
      if (g_cyc[1] - g_cyc[0] != 6) begin
         fails++; $display("FAIL all_four_interval: got %0d cycles, need 6", g_cyc[1] - g_cyc[0]);
      end
   endtask

   task automatic test_fairness();
      int exp_g[7];
      int b;
      exp_g = '{1, 3, 1, 3, 0, 1, 3};
      do_reset(2);
      m_len = 1;
      op_l[1] = 32'h80000000; op_r[1] = 32'h00000000; op_as[1] = 1'b1;
      op_l[3] = 32'h40490fdb; op_r[3] = 32'h402df854; op_as[3] = 1'b1;
      op_l[0] = 32'h4d001f73; op_r[0] = 32'h44030a3d; op_as[0] = 1'b1;
      rem[1] = 100; rem[3] = 100;
      drive_reqs();
      b = 0;
      while (g_idx.size() < 4 && b < 100) begin tick(); b++; end
      rem[0] = 1;
      drive_reqs();
      while (g_idx.size() < 7 && b < 200) begin tick(); b++; end
      tests++;
      if (g_idx.size() < 7) begin fails++; $display("FAIL fair_wait: got %0d grants, need 7", g_idx.size()); end
      for (int i = 0; i < 7; i++) begin
         tests++;
         if (g_idx[i] != exp_g[i]) begin
            fails++; $display("FAIL fair_grant%0d: got %0d, need %0d", i, g_idx[i], exp_g[i]);
         end
      end
      for (int i = 0; i < N; i++) rem[i] = 0;
      drive_reqs();
      repeat (12) tick();
   endtask

   task automatic test_timeout();
      int d;
      do_reset(2);
      m_len = 3;
      m_stuck = 1'b1;
      op_l[2] = 32'h40490fdb; op_r[2] = 32'h402df854; op_as[2] = 1'b1; rem[2] = 1;
      drive_reqs();
      run_until_resp(1, 150, "timeout");
      d = rs_cyc[0] - ld_cyc[0];
      tests++;
      if (rs_idx[0] != 2 || rs_err[0] !== 1'b1 || err_pulses != 1) begin
         fails++; $display("FAIL timeout_flag: idx=%0d err=%b pulses=%0d, need 2 1 1", rs_idx[0], rs_err[0], err_pulses);
      end
      tests++;
      if (rs_sum[0] !== 32'h7FC00000 || rs_st[0] !== 3'b100) begin
         fails++; $display("FAIL timeout_value: sum=%h st=%b, need 7fc00000 100", rs_sum[0], rs_st[0]);
      end
      tests++;
      if (d > TMO || d < TMO / 2) begin
         fails++; $display("FAIL timeout_latency: %0d cycles after load, need %0d..%0d", d, TMO / 2, TMO);
      end
      m_stuck = 1'b0;
      op_l[1] = 32'h4d001f73; op_r[1] = 32'h44030a3d; op_as[1] = 1'b1; rem[1] = 1;
      drive_reqs();
      run_until_resp(2, 100, "after_timeout");
      tests++;
      if (rs_idx[1] != 1 || rs_sum[1] !== 32'h4D001F94 || rs_err[1] !== 1'b0 || err_pulses != 1) begin
         fails++; $display("FAIL after_timeout_resp: idx=%0d sum=%h err=%b pulses=%0d, need 1 4d001f94 0 1", rs_idx[1], rs_sum[1], rs_err[1], err_pulses);
      end
      tests++;
      if (bad_grants != 0) begin fails++; $display("FAIL busy_blocks_grant: %0d bad grants, need 0", bad_grants); end
   endtask

   task automatic test_reset_mid();
      int b;
      do_reset(2);
      m_len = 10;
      op_l[3] = 32'h7FC00000; op_r[3] = 32'h402df854; op_as[3] = 1'b1; rem[3] = 1;
      op_l[0] = 32'h40490fdb; op_r[0] = 32'h402df854; op_as[0] = 1'b1;
      drive_reqs();
      b = 0;
      while (ld_cyc.size() < 1 && b < 20) begin tick(); b++; end
      repeat (4) tick();
      tests++;
      if (ctl_busy !== 1'b1 || rs_idx.size() != 0) begin
         fails++; $display("FAIL midreset_pre: busy=%b resp=%0d, need 1 0", ctl_busy, rs_idx.size());
      end
      nRST = 1'b0;
      rem[0] = 1;
      drive_reqs();
      tick();
      tests++;
      if ({ctl_busy, resp_valid, err_timeout, fa_load, req_ready} !== '0 || {fa_left, fa_right, resp_sum, resp_status} !== '0) begin
         fails++; $display("FAIL midreset_outputs: busy=%b rv=%b err=%b load=%b rdy=%b left=%h sum=%h, need 0", ctl_busy, resp_valid, err_timeout, fa_load, req_ready, fa_left, resp_sum);
      end
      nRST = 1'b1;
      clear_logs();
      rem[3] = 1;
      drive_reqs();
      run_until_resp(2, 100, "midreset");
      tests++;
      if (g_idx[0] != 0 || rs_idx[0] != 0 || rs_sum[0] !== 32'h40bb8417) begin
         fails++; $display("FAIL midreset_first: grant=%0d resp=%0d sum=%h, need 0 0 40bb8417", g_idx[0], rs_idx[0], rs_sum[0]);
      end
      tests++;
      if (rs_idx[1] != 3 || rs_sum[1] !== 32'h7FC00000 || rs_st[1] !== 3'b100 || rs_err[1] !== 1'b0) begin
         fails++; $display("FAIL midreset_nan: idx=%0d sum=%h st=%b err=%b, need 3 7fc00000 100 0", rs_idx[1], rs_sum[1], rs_st[1], rs_err[1]);
      end
   endtask

   task automatic test_withdraw();
      int b;
      do_reset(2);
      m_len = 6;
      op_l[0] = 32'h40490fdb; op_r[0] = 32'h402df854; op_as[0] = 1'b0; rem[0] = 1;
      op_l[2] = 32'h80000000; op_r[2] = 32'h00000000; op_as[2] = 1'b1;
      drive_reqs();
      b = 0;
      while (g_idx.size() < 1 && b < 10) begin tick(); b++; end
      tick();
      rem[2] = 1;
      drive_reqs();
      tick();
      rem[2] = 0;
      drive_reqs();
      run_until_resp(1, 50, "withdraw");
      repeat (15) tick();
      tests++;
      if (g_idx.size() != 1 || rs_idx.size() != 1 || rs_idx[0] != 0) begin
         fails++; $display("FAIL withdraw: grants=%0d resps=%0d idx=%0d, need 1 1 0", g_idx.size(), rs_idx.size(), rs_idx[0]);
      end
      tests++;
      if (ld_as[0] !== 1'b0) begin fails++; $display("FAIL subtract_select: fa_addsub=%b, need 0", ld_as[0]); end
   endtask

   initial begin
      m_len = 3;
      m_stuck = 1'b0;
      clear_logs();
      test_reset();
      test_single();
      test_no_busy();
      test_all_four();
      test_fairness();
      test_timeout();
      test_reset_mid();
      test_withdraw();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation did not complete, %0d failed so far", fails);
      $fatal(1);
   end

endmodule

// File: doc/fadd_arbiter.md
Name: fadd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Float32Add instance between N_REQ requesters.
- Accepts one operation per requester through a valid/ready handshake and drives the adder's argument, addSub and loadArgs pins.
- Tracks the adder's busy line and returns sum/status to the granted requester as a one-cycle response pulse.
- Includes a watchdog so a stuck adder cannot hang the shared resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles allowed in any adder-wait state before abort.

Ports:
- clk  in  1  clock, rising edge active.
- nRST  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  one-hot acceptance pulse.
- req_left  in  32*N_REQ  left operand; slice i belongs to requester i.
- req_right  in  32*N_REQ  right operand; slice i belongs to requester i.
- req_addsub  in  N_REQ  operation select: 1 = add, 0 = subtract.
- resp_valid  out  N_REQ  one-hot result pulse.
- resp_sum  out  32  result word, shared by all requesters.
- resp_status  out  3  result status, shared: bit2 NaN, bit1 Inf, bit0 Denormal.
- err_timeout  out  1  one-cycle pulse on watchdog abort.
- ctl_busy  out  1  high from acceptance through response.
- fa_left  out  32  to adder leftArg.
- fa_right  out  32  to adder rightArg.
- fa_addsub  out  1  to adder addSub.
- fa_load  out  1  to adder loadArgs; one-cycle strobe.
- fa_status  in  3  from adder status.
- fa_busy  in  1  from adder busy.
- fa_sum  in  32  from adder sum.

Behaviour:
- Reset, nRST low at a rising edge:
  - state=IDLE, rr pointer=N_REQ-1 (requester 0 has first priority).
  - All outputs 0, watchdog cleared.
  - Applies mid-operation too: the in-flight operation is dropped with no response. The adder shares the same nRST.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Grant only when req_valid!=0 and fa_busy==0.
  - Winner = first set req_valid bit searching upward from rr+1, modulo N_REQ.
  - Same cycle: req_ready[winner]=1 (combinational from state/req_valid/fa_busy). Operands and addsub are captured into fa_left/fa_right/fa_addsub registers. Winner index is stored and rr<=winner. Next state is LOAD.
- Requester rules:
  - Must hold req_valid and operands stable until it sees req_ready.
  - Dropping req_valid before grant is legal: it withdraws the request.
- LOAD: fa_load=1 for exactly this cycle, then WAIT_BUSY. fa_* operand registers stay stable from LOAD until exit from WAIT_DONE.
- WAIT_BUSY:
  - fa_busy==1 -> WAIT_DONE.
  - fa_busy still 0 after 2 cycles -> WAIT_DONE anyway. This covers single-cycle adders whose busy pulse was missed or never asserted.
- WAIT_DONE: fa_busy==0 -> latch fa_sum into resp_sum and fa_status into resp_status, then RESP.
- RESP:
  - resp_valid[winner]=1 for one cycle, then IDLE.
  - resp_sum/resp_status hold their value until the next RESP.
- Watchdog:
  - Counts cycles spent in WAIT_BUSY+WAIT_DONE.
  - Reaching TIMEOUT forces RESP with resp_sum=32'h7FC00000, resp_status=3'b100, err_timeout=1 for that cycle.
  - Counter clears on entering LOAD.
- ctl_busy = (state != IDLE).
- Back-to-back: at most one grant per IDLE visit. Minimum issue interval = 4 cycles + adder busy length.
- Latency: accept at T -> fa_load at T+1 -> resp_valid one cycle after fa_busy is first sampled low in WAIT_DONE.
- New requests that arrive mid-operation wait. req_ready stays 0 outside IDLE.
- Simultaneous events:
  - A requester may reassert req_valid in its own RESP cycle; it competes normally in the next IDLE.
  - Round robin guarantees each continuously-valid requester a grant within N_REQ operations.
- fa_busy high while in IDLE (adder not yet settled after reset) blocks grants.

Test Plan:
- Single request: req0 valid, left=40490fdb, right=402df854, addsub=1 -> req_ready[0] one cycle, then fa_load one cycle, resp_valid[0], resp_sum=40bb8417, resp_status=000.
- All four requesters valid from reset: req0 4d001f73+44030a3d, req1 80000000+00000000, req2 40490fdb+402df854, req3 7FC00000+402df854.
  - Responses must arrive in order 0,1,2,3.
  - Expected sums: 4D001F94, 00000000, 40bb8417, NaN with resp_status[2]=1.
- Fairness: req1 and req3 continuously valid -> grants alternate 1,3,1,3. After req0 joins, next order is 0,1,3.
- Timeout: adder model holds busy=1 forever, TIMEOUT=64 -> err_timeout and resp_valid on the same cycle, no later than 64 cycles after fa_load, with resp_sum=7FC00000, resp_status=100. Next request is then accepted.
- Reset mid-operation: nRST low during WAIT_DONE -> next edge has state IDLE and all outputs 0, no resp_valid for the dropped op. First post-reset grant goes to requester 0.
- Request withdrawal: req2 raises valid for 1 cycle while the controller is busy, then drops -> no grant and no response for req2.
